// File: rtl/key_conditioner.sv
// Four-button conditioner: per-bit 2-flop synchroniser, debounce FSM and optional hold-to-repeat.
// Every accepted press or repeat gives a one-cycle key_event and a PULSE_LEN-cycle low on key_out.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int PULSE_LEN       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic       repeat_en,
  output logic [3:0] key_out,
  output logic [3:0] key_event,
  output logic [3:0] key_level
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_B = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int MAX_P = (MAX_B > PULSE_LEN) ? MAX_B : PULSE_LEN;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int PW    = $clog2(PULSE_LEN + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HOLD_WAIT,
    HOLD_REPEAT,
    DB_RELEASE
  } state_t;

  logic [3:0] sync_a;
  logic [3:0] sync_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= KEY;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bit
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] pulse_cnt;
    logic          evt;
    logic          level_q;
    logic          level_nxt;
    logic          event_q;
    logic          out_q;
    logic          in_bit;

    assign in_bit = sync_b[i];

    // A release seen on the threshold cycle wins over the repeat event.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      evt       = 1'b0;
      level_nxt = level_q;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!in_bit) state_nxt = DB_PRESS;
        end
        DB_PRESS: begin
          if (in_bit) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = HOLD_WAIT;
            cnt_nxt   = '0;
            evt       = 1'b1;
            level_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HOLD_WAIT: begin
          if (in_bit) begin
            state_nxt = DB_RELEASE;
            cnt_nxt   = '0;
          end else if (cnt == RD_LAST) begin
            if (repeat_en) begin
              state_nxt = HOLD_REPEAT;
              cnt_nxt   = '0;
              evt       = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (in_bit) begin
            state_nxt = DB_RELEASE;
            cnt_nxt   = '0;
          end else if (!repeat_en) begin
            state_nxt = HOLD_WAIT;
            cnt_nxt   = RD_LAST;
          end else if (cnt == RP_LAST) begin
            cnt_nxt = '0;
            evt     = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DB_RELEASE: begin
          if (!in_bit) begin
            state_nxt = HOLD_WAIT;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b1;
        event_q   <= 1'b0;
        pulse_cnt <= '0;
        out_q     <= 1'b1;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        event_q <= evt;
        if (evt) begin
          pulse_cnt <= PULSE_LOAD;
          out_q     <= 1'b0;
        end else if (pulse_cnt > PW'(1)) begin
          pulse_cnt <= pulse_cnt - PW'(1);
          out_q     <= 1'b0;
        end else begin
          pulse_cnt <= '0;
          out_q     <= 1'b1;
        end
      end
    end

    assign key_out[i]   = out_q;
    assign key_event[i] = event_q;
    assign key_level[i] = level_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: a per-cycle behavioural model plus literal event-time checks.
// The model describes each button in terms of run lengths and event times, not FSM states.
module tb_key_conditioner;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int PL   = 2;
  localparam int HIST = 2048;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic       repeat_en = 1'b0;
  logic [3:0] key_out;
  logic [3:0] key_event;
  logic [3:0] key_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  logic [3:0] ev_hist  [HIST];
  logic [3:0] out_hist [HIST];
  logic [3:0] lvl_hist [HIST];
  int exp_q[$];

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .PULSE_LEN(PL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY(KEY),
    .repeat_en(repeat_en),
    .key_out(key_out),
    .key_event(key_event),
    .key_level(key_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: a press is accepted after D+1 consecutive low observations,
  // a release after D+1 consecutive highs; while held, repeats fall at fixed times.
  logic [3:0] ms1, ms2;
  bit  m_held [4];
  int  m_run  [4];
  int  m_next [4];
  int  m_last [4];
  bit  m_has  [4];
  int  mcyc;
  logic [3:0] m_event, m_out, m_level;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms1 = 4'hF;
      ms2 = 4'hF;
      mcyc = 0;
      for (int b = 0; b < 4; b++) begin
        m_held[b] = 1'b0; m_run[b] = 0; m_next[b] = 0; m_last[b] = 0; m_has[b] = 1'b0;
      end
      m_event = 4'h0; m_out = 4'hF; m_level = 4'hF;
    end else begin
      for (int b = 0; b < 4; b++) begin
        bit obs, ev;
        obs = ms2[b];
        ev = 1'b0;
        if (!m_held[b]) begin
          m_run[b] = obs ? 0 : m_run[b] + 1;
          if (m_run[b] == D + 1) begin
            m_held[b] = 1'b1; m_run[b] = 0; ev = 1'b1; m_next[b] = mcyc + RD;
          end
        end else if (obs) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == D + 1) begin
            m_held[b] = 1'b0; m_run[b] = 0;
          end
        end else if (m_run[b] > 0) begin
          m_run[b] = 0; m_next[b] = mcyc + RD;
        end else if (repeat_en && mcyc == m_next[b]) begin
          ev = 1'b1; m_next[b] = mcyc + RP;
        end
        if (ev) begin
          m_last[b] = mcyc; m_has[b] = 1'b1;
        end
        m_event[b] = ev;
        m_out[b]   = !(m_has[b] && (mcyc - m_last[b] < PL));
        m_level[b] = !m_held[b];
      end
      ms2 = ms1;
      ms1 = KEY;
      mcyc++;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < HIST) begin
      ev_hist[cyc]  <= key_event;
      out_hist[cyc] <= key_out;
      lvl_hist[cyc] <= key_level;
    end
    if (check_en) begin
      chk("model key_event", key_event, m_event);
      chk("model key_out",   key_out,   m_out);
      chk("model key_level", key_level, m_level);
    end
  end

  task automatic check_events(input string name, input int b, input int start, input int len);
    int act_q[$];
    for (int c = start; c < start + len; c++)
      if (c < HIST && ev_hist[c][b]) act_q.push_back(c - start);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s event count: got %0d expected %0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] != exp_q[i]) begin
        failures++;
        $display("FAIL %s event %0d offset: got %0d expected %0d", name, i, act_q[i], exp_q[i]);
      end
    end
  endtask

  // Called on a negedge; KEY[b] is low for low_len samples starting at edge cyc+1.
  task automatic press(input int b, input int low_len, input int tail, output int start);
    KEY[b] = 1'b0;
    start = cyc + 1;
    repeat (low_len) @(negedge clk);
    KEY[b] = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " key_out"},   key_out,   4'hF);
    chk({name, " key_event"}, key_event, 4'h0);
    chk({name, " key_level"}, key_level, 4'hF);
  endtask

  initial begin
    int s, s2;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset");
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // clean press on KEY[0]
    repeat_en = 1'b1;
    press(0, 10, 20, s);
    exp_q = '{6};
    check_events("clean press", 0, s, 28);
    chk("clean out off5",  {3'b0, out_hist[s + 5][0]}, 4'h1);
    chk("clean out off6",  {3'b0, out_hist[s + 6][0]}, 4'h0);
    chk("clean out off7",  {3'b0, out_hist[s + 7][0]}, 4'h0);
    chk("clean out off8",  {3'b0, out_hist[s + 8][0]}, 4'h1);
    chk("clean lvl off5",  {3'b0, lvl_hist[s + 5][0]}, 4'h1);
    chk("clean lvl off6",  {3'b0, lvl_hist[s + 6][0]}, 4'h0);
    chk("clean lvl off15", {3'b0, lvl_hist[s + 15][0]}, 4'h0);
    chk("clean lvl off16", {3'b0, lvl_hist[s + 16][0]}, 4'h1);

    // bounce on KEY[1]: 3 low / 3 high for 30 cycles, then steady low
    s = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      KEY[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    press(1, 20, 20, s2);
    exp_q = '{36};
    check_events("bounce", 1, s, 68);

    // hold-to-repeat on KEY[2]
    repeat_en = 1'b1;
    press(2, 60, 20, s);
    exp_q = '{6, 26, 34, 42, 50, 58};
    check_events("repeat", 2, s, 78);

    // same hold with repeat disabled
    repeat_en = 1'b0;
    press(2, 60, 20, s);
    exp_q = '{6};
    check_events("repeat off", 2, s, 78);

    // simultaneous KEY[3] and KEY[0]
    repeat_en = 1'b1;
    KEY[3] = 1'b0;
    KEY[0] = 1'b0;
    s = cyc + 1;
    repeat (10) @(negedge clk);
    KEY[3] = 1'b1;
    KEY[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("simultaneous events", ev_hist[s + 6], 4'b1001);
    exp_q = '{6};
    check_events("simul bit0", 0, s, 28);
    check_events("simul bit3", 3, s, 28);

    // reset in the middle of a key_out pulse
    KEY[0] = 1'b0;
    s = cyc + 1;
    repeat (7) @(negedge clk);
    chk("pre-reset pulse low", {3'b0, key_out[0]}, 4'h0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset mid-pulse");
    KEY[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    s2 = cyc + 1;
    repeat (22) @(negedge clk);
    exp_q.delete();
    check_events("after reset pulse", 0, s2, 20);

    // reset while repeating
    KEY[2] = 1'b0;
    s = cyc + 1;
    repeat (31) @(negedge clk);
    chk("pre-reset repeat level", {3'b0, key_level[2]}, 4'h0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset in repeat");
    KEY[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    s2 = cyc + 1;
    repeat (22) @(negedge clk);
    exp_q.delete();
    check_events("after reset repeat", 2, s2, 20);

    // fresh press after reset is accepted normally
    press(2, 10, 20, s);
    exp_q = '{6};
    check_events("fresh press", 2, s, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
